// File: rtl/seqdet_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seqdet_pkg
// Purpose  : Shared elaboration helpers for the Moore serial pattern detector:
//            the state-register width, the KMP failure value F, the KMP
//            next-state function and parameter-legality checks.
// Ports    : none (package)
// Config   : SEQDET_MATCH_CNT_EN is consumed by moore_pattern_detector, not here.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package seqdet_pkg;

    // Largest pattern the helpers can represent.
    localparam int c_PAT_LEN_MAX = 16;

    // Pattern bits zero-extended to the widest legal pattern.
    typedef logic [c_PAT_LEN_MAX-1:0] pat_word_t;

    // Detection mode as decoded from the overlap input.
    typedef enum logic {
        DET_NONOVERLAP = 1'b0,
        DET_OVERLAP    = 1'b1
    } det_mode_e;

    // States S0..S<pat_len> need pat_len+1 codes.
    function automatic int seqdet_state_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

    // Bit at position pos of the pattern word. A shift keeps the select
    // width-clean for any integer position.
    function automatic logic pat_bit(input pat_word_t pat, input int pos);
        pat_word_t t;
        t = pat >> pos;
        return t[0];
    endfunction

    // Longest proper prefix of the pattern that is also a suffix. The i-th
    // received bit of the pattern is pat[len-1-i]; the i-th received bit of
    // the length-j suffix is pat[j-1-i].
    function automatic int seqdet_failure(input pat_word_t pat, input int len);
        int   f;
        logic ok;
        f = 0;
        for (int j = 1; j < len; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (pat_bit(pat, len - 1 - i) != pat_bit(pat, j - 1 - i)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                f = j;
            end
        end
        return f;
    endfunction

    // Next state from Sk on input xb. The history is the first k pattern
    // bits followed by xb; the result is the longest j <= k+1 whose last j
    // history bits equal the first j pattern bits. j is scanned upward so
    // the last hit is the longest.
    function automatic int seqdet_next(input pat_word_t pat, input int len,
                                       input int k, input logic xb);
        int   nxt;
        int   p;
        logic hb;
        logic ok;
        nxt = 0;
        for (int j = 1; j <= k + 1; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                p  = k + 1 - j + i;
                hb = (p == k) ? xb : pat_bit(pat, len - 1 - p);
                if (hb != pat_bit(pat, len - 1 - i)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                nxt = j;
            end
        end
        return nxt;
    endfunction

    function automatic bit seqdet_params_ok(input int pat_len, input int cnt_w);
        return (pat_len >= 2) && (pat_len <= c_PAT_LEN_MAX) &&
               (cnt_w >= 1) && (cnt_w <= 32);
    endfunction

endpackage : seqdet_pkg
`default_nettype wire

// File: rtl/seqdet_match_counter.sv
`default_nettype none
// ============================================================================
// Module   : seqdet_match_counter
// Purpose  : Saturating detection counter for the serial pattern detector.
// Ports    : clk      - clock, rising edge active
//            rst      - asynchronous active-low reset
//            en       - sample enable; increments only when high
//            cnt_clr  - synchronous clear, wins over increment, ignores en
//            inc      - a detection completes on this edge
//            cnt      - current count, saturates at 2^CNT_W-1
// Config   : instantiated only when SEQDET_MATCH_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module seqdet_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cnt_clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (en && inc && (cnt_q != c_CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule : seqdet_match_counter
`default_nettype wire

// File: rtl/moore_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module   : moore_pattern_detector
// Purpose  : Parametrised Moore serial pattern detector. One bit of x is
//            sampled per enabled clock; z is high while the FSM sits in the
//            detect state. Overlapping or non-overlapping detection is
//            selected at run time by the overlap input.
// Ports    : clk       - clock, rising edge active
//            rst       - asynchronous active-low reset
//            en        - sample enable; 0 holds state, z and match_cnt
//            x         - serial data bit
//            overlap   - 1 overlapping, 0 non-overlapping detection
//            cnt_clr   - synchronous clear of match_cnt (acts regardless of en)
//            z         - detect flag (registered, pure function of state)
//            match_cnt - saturating detection count
// Config   : SEQDET_MATCH_CNT_EN - when defined the match counter is built;
//            otherwise match_cnt is tied to 0 and cnt_clr is ignored.
// Revision : 1.0 - initial parametrised release (successor of fixed 1010)
// ============================================================================
module moore_pattern_detector
    import seqdet_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt
);

    // ------------------------------------------------------------------
    // Elaboration constants
    // ------------------------------------------------------------------
    localparam int        c_SW      = seqdet_state_w(PAT_LEN);
    localparam int        c_NSTATES = 2 ** c_SW;
    localparam pat_word_t c_PAT_EXT = pat_word_t'(PATTERN);
    localparam int        c_FAIL    = seqdet_failure(c_PAT_EXT, PAT_LEN);

    localparam logic [c_SW-1:0] c_S_IDLE = '0;
    localparam logic [c_SW-1:0] c_S_FAIL = c_SW'(c_FAIL);
    localparam logic [c_SW-1:0] c_S_DET  = c_SW'(PAT_LEN);

    if (!seqdet_params_ok(PAT_LEN, CNT_W)) begin : g_bad_params
        $fatal(1, "moore_pattern_detector: PAT_LEN must be 2..16 and CNT_W 1..32");
    end

    // ------------------------------------------------------------------
    // Next-state table. Rows cover every code of the state register so
    // an unreachable code (above S<PAT_LEN>) falls back to S0. The detect
    // row itself is never read: leaving detect reuses the S0 or S<F> row.
    // ------------------------------------------------------------------
    logic [c_SW-1:0] w_nxt_tbl [c_NSTATES][2];

    for (genvar k = 0; k < c_NSTATES; k++) begin : g_row
        for (genvar b = 0; b < 2; b++) begin : g_col
            if (k < PAT_LEN) begin : g_live
                localparam int c_NXT = seqdet_next(c_PAT_EXT, PAT_LEN, k, 1'(b));
                assign w_nxt_tbl[k][b] = c_SW'(c_NXT);
            end else begin : g_dead
                assign w_nxt_tbl[k][b] = c_S_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register and next-state selection
    // ------------------------------------------------------------------
    logic [c_SW-1:0] state_q;
    logic [c_SW-1:0] state_d;
    logic [c_SW-1:0] w_src;
    logic            z_q;
    det_mode_e       w_mode;

    assign w_mode = det_mode_e'(overlap);

    always_comb begin
        w_src = state_q;
        // On exit from detect, the matched bits are either discarded (S0)
        // or the border of the pattern is kept as a partial match (S<F>).
        if (state_q == c_S_DET) begin
            w_src = (w_mode == DET_OVERLAP) ? c_S_FAIL : c_S_IDLE;
        end
        state_d = w_nxt_tbl[w_src][x];
    end

    // z is registered alongside the state so it is exactly "state == detect"
    // with no combinational path from x.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= c_S_IDLE;
            z_q     <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            z_q     <= (state_d == c_S_DET);
        end
    end

    assign z = z_q;

    // ------------------------------------------------------------------
    // Optional match counter
    // ------------------------------------------------------------------
`ifdef SEQDET_MATCH_CNT_EN
    logic w_hit;

    assign w_hit = (state_d == c_S_DET);

    seqdet_match_counter #(
        .CNT_W   (CNT_W)
    ) u_match_counter (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cnt_clr (cnt_clr),
        .inc     (w_hit),
        .cnt     (match_cnt)
    );
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign match_cnt        = '0;
`endif

endmodule : moore_pattern_detector
`default_nettype wire

// File: tb/tb_moore_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_moore_pattern_detector
// Purpose  : Directed self-checking bench for moore_pattern_detector.
//            Three instances share the stimulus: A (1010, CNT_W=8),
//            B (11011, CNT_W=8) and C (1010, CNT_W=2). Each phase checks
//            the instance it targets. Expected counts follow
//            SEQDET_MATCH_CNT_EN (tied to 0 when it is undefined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_moore_pattern_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       x;
    logic       overlap;
    logic       cnt_clr;
    logic       z_a, z_b, z_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    moore_pattern_detector u_dut_a (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
        .cnt_clr(cnt_clr), .z(z_a), .match_cnt(cnt_a)
    );

    moore_pattern_detector #(
        .PAT_LEN(5), .PATTERN(5'b11011), .CNT_W(8)
    ) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
        .cnt_clr(cnt_clr), .z(z_b), .match_cnt(cnt_b)
    );

    moore_pattern_detector #(
        .PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(2)
    ) u_dut_c (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
        .cnt_clr(cnt_clr), .z(z_c), .match_cnt(cnt_c)
    );

    function automatic logic [31:0] exp_cnt(input int c);
`ifdef SEQDET_MATCH_CNT_EN
        return 32'(c);
`else
        return 32'(c) & 32'd0;
`endif
    endfunction

    function automatic logic pick_z(input int which);
        case (which)
            0:       return z_a;
            1:       return z_b;
            default: return z_c;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one bit, let the rising edge take it, sample 1 time unit later.
    task automatic step(input logic xv);
        x = xv;
        @(posedge clk);
        #1;
    endtask

    // Feed n bits MSB-first and check z of the chosen instance after each.
    task automatic feed(input string tag, input int which, input int n,
                        input logic [15:0] bits, input logic [15:0] ez);
        logic [15:0] tb;
        logic [15:0] te;
        for (int i = 0; i < n; i++) begin
            tb = bits >> (n - 1 - i);
            te = ez >> (n - 1 - i);
            step(tb[0]);
            chk($sformatf("%s z bit%0d", tag, i + 1), {31'd0, pick_z(which)}, {31'd0, te[0]});
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        en      = 1'b1;
        x       = 1'b0;
        overlap = 1'b0;
        cnt_clr = 1'b0;

        // Reset held with x toggling: outputs stay clear.
        for (int i = 0; i < 4; i++) begin
            step(i[0] ? 1'b0 : 1'b1);
            chk("rst z", {31'd0, z_a}, 32'd0);
            chk("rst cnt", 32'(cnt_a), 32'd0);
        end
        rst = 1'b1;
        feed("first", 0, 4, 16'b1010, 16'b0001);
        chk("first cnt", 32'(cnt_a), exp_cnt(1));
        step(1'b1);
        chk("first pulse width", {31'd0, z_a}, 32'd0);

        // Non-overlapping, 10101010.
        do_reset();
        overlap = 1'b0;
        feed("nonovl", 0, 8, 16'hAA, 16'h11);
        chk("nonovl cnt", 32'(cnt_a), exp_cnt(2));

        // Overlapping, same stream.
        do_reset();
        overlap = 1'b1;
        feed("ovl", 0, 8, 16'hAA, 16'h15);
        chk("ovl cnt", 32'(cnt_a), exp_cnt(3));

        // Mode flipped to non-overlap right after the first detection.
        do_reset();
        overlap = 1'b1;
        feed("flip a", 0, 4, 16'b1010, 16'b0001);
        overlap = 1'b0;
        feed("flip b", 0, 4, 16'b1010, 16'b0001);
        chk("flip cnt", 32'(cnt_a), exp_cnt(2));

        // Five-bit pattern 11011 with F=2.
        do_reset();
        overlap = 1'b1;
        feed("p5 a", 1, 8, 16'b11011011, 16'b00001001);
        chk("p5 a cnt", 32'(cnt_b), exp_cnt(2));
        do_reset();
        feed("p5 b", 1, 6, 16'b111011, 16'b000001);
        chk("p5 b cnt", 32'(cnt_b), exp_cnt(1));

        // Enable gating mid-pattern and while detect is held.
        do_reset();
        overlap = 1'b0;
        feed("en pre", 0, 2, 16'b10, 16'b00);
        en = 1'b0;
        feed("en gap", 0, 3, 16'b101, 16'b000);
        en = 1'b1;
        feed("en post", 0, 2, 16'b10, 16'b01);
        chk("en cnt", 32'(cnt_a), exp_cnt(1));
        en = 1'b0;
        feed("en hold", 0, 2, 16'b01, 16'b11);
        chk("en hold cnt", 32'(cnt_a), exp_cnt(1));
        en = 1'b1;
        feed("en exit", 0, 1, 16'b0, 16'b0);
        chk("en exit cnt", 32'(cnt_a), exp_cnt(1));

        // Two-bit counter saturation and clear priority.
        do_reset();
        overlap = 1'b1;
        feed("sat 1", 2, 4, 16'b1010, 16'b0001);
        chk("sat cnt1", 32'(cnt_c), exp_cnt(1));
        feed("sat 2", 2, 2, 16'b10, 16'b01);
        chk("sat cnt2", 32'(cnt_c), exp_cnt(2));
        feed("sat 3", 2, 2, 16'b10, 16'b01);
        chk("sat cnt3", 32'(cnt_c), exp_cnt(3));
        feed("sat 4", 2, 4, 16'b1010, 16'b0101);
        chk("sat cnt5", 32'(cnt_c), exp_cnt(3));
        step(1'b1);
        cnt_clr = 1'b1;
        step(1'b0);
        chk("clr det z", {31'd0, z_c}, 32'd1);
        chk("clr det cnt", 32'(cnt_c), 32'd0);
        cnt_clr = 1'b0;
        feed("after clr", 2, 2, 16'b10, 16'b01);
        chk("after clr cnt", 32'(cnt_c), exp_cnt(1));
        en      = 1'b0;
        cnt_clr = 1'b1;
        step(1'b0);
        chk("clr no en cnt", 32'(cnt_c), 32'd0);
        chk("clr no en z", {31'd0, z_c}, 32'd1);
        cnt_clr = 1'b0;
        en      = 1'b1;

        // Asynchronous reset in the middle of a partial match.
        do_reset();
        overlap = 1'b0;
        feed("arst pre", 0, 4, 16'b1010, 16'b0001);
        chk("arst pre cnt", 32'(cnt_a), exp_cnt(1));
        feed("arst part", 0, 3, 16'b101, 16'b000);
        #2;
        rst = 1'b0;
        #1;
        chk("arst async cnt", 32'(cnt_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        feed("arst lost", 0, 1, 16'b0, 16'b0);
        feed("arst full", 0, 4, 16'b1010, 16'b0001);
        chk("arst cnt", 32'(cnt_a), exp_cnt(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_moore_pattern_detector
`default_nettype wire

// File: doc/moore_pattern_detector.md
# moore_pattern_detector

Parametrised Moore-style serial pattern detector, the next generation of our fixed 1010 non-overlapping detector. One bit of serial input `x` is sampled per enabled clock. A one-cycle Moore pulse `z` is raised each time a compile-time pattern of configurable length completes. Overlapping or non-overlapping detection is selectable at run time, and an optional saturating match counter is provided. It sits directly on a serial data line as a framing/flag detector.

## Interface
- `PAT_LEN`, 4, pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1010, pattern bits; `PATTERN[PAT_LEN-1]` is the first bit received.
- `CNT_W`, 8, match counter width; legal range 1..32.
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `en`  input  1  sample enable; when 0, state and counter hold and `x` is ignored.
- `x`  input  1  serial data bit.
- `overlap`  input  1  1 = overlapping detection, 0 = non-overlapping.
- `cnt_clr`  input  1  synchronous clear of `match_cnt`.
- `z`  output  1  Moore detect flag.
- `match_cnt`  output  CNT_W  number of detections since reset/clear, saturating.

## Operation
- States S0..S`PAT_LEN`. Sk means the last k sampled bits equal the first k pattern bits. S`PAT_LEN` is the detect state.
- `z` = 1 iff state == S`PAT_LEN`. It is a pure function of state, with no path from `x`.
- From Sk (k < PAT_LEN): go to the longest j ≤ k+1 such that the last j bits (including `x`) equal the first j pattern bits (KMP transition). The table is computed at elaboration.
- Leaving S`PAT_LEN` with `overlap`=0: apply the S0 transition to `x` (the matched bits are discarded).
- Leaving S`PAT_LEN` with `overlap`=1: apply the transition of S`F` to `x`. F is the longest proper prefix of PATTERN that is also its suffix (F = 2 for 1010).
- `overlap` is sampled every enabled edge and only matters when leaving S`PAT_LEN`. A mid-stream mode change is legal and takes effect on the next exit from detect.
- `en`=0: state, `z` and `match_cnt` hold. A detect pulse therefore stretches while `en` is low.
- `match_cnt` increments by 1 on each enabled edge whose next state is S`PAT_LEN`. It saturates at 2^CNT_W−1.
- `cnt_clr` has priority over a simultaneous increment: the result is 0. `cnt_clr` acts regardless of `en`.

## Timing
- Reset (async assert, sync release by the system): state S0, `z`=0, `match_cnt`=0.
- Reset asserted mid-pattern: partial match lost immediately; detection restarts from S0.
- Latency: the final pattern bit is sampled at edge N, and `z` is high from edge N until edge N+1 (one clock with `en` held 1).
- `match_cnt` updates on the same edge that raises `z`.
- Back-to-back detections in overlap mode can occur at most every PAT_LEN−F enabled cycles. In non-overlap mode the minimum spacing is PAT_LEN enabled cycles.

## Configuration
- `SEQDET_MATCH_CNT_EN` defined: counter logic present and `match_cnt` behaves as above.
- Not defined: no counter flops are built, `match_cnt` is tied to 0 and `cnt_clr` is ignored. The port list is unchanged.

## Structure
- Shared package `seqdet_pkg`:
  - state-width constant function (`$clog2(PAT_LEN+1)`);
  - elaboration functions computing the failure value F and the next-state table from PATTERN/PAT_LEN;
  - parameter-legality checks.
- Sub-module `seqdet_match_counter`: the saturating counter with `en`, `cnt_clr` and increment inputs. It is instantiated only under `SEQDET_MATCH_CNT_EN`.

## Test plan
- Reset: hold `rst`=0 with `x` toggling → `z`=0 and `match_cnt`=0 throughout. Release, then feed 1,0,1,0 → `z` high for exactly one cycle after the 4th bit, `match_cnt`=1.
- Non-overlap, default pattern, `x` = 1,0,1,0,1,0,1,0 → `z` pulses after bits 4 and 8 only, `match_cnt`=2.
- Overlap, same stream → `z` pulses after bits 4, 6 and 8, `match_cnt`=3. Flip `overlap` 1→0 after bit 4 → pulse after bit 8 only.
- PAT_LEN=5, PATTERN=5'b11011, overlap, `x` = 1,1,0,1,1,0,1,1 → pulses after bits 5 and 8 (F=2). `x` = 1,1,1,0,1,1 → pulse after bit 6.
- `en`=0 for 3 cycles mid-pattern with `x` toggling → match resumes unaffected. `en`=0 while `z`=1 → `z` stays high and the count does not increment again.
- CNT_W=2, 5 detections → `match_cnt` saturates at 3. `cnt_clr` together with a detect → 0. Async reset during a partial match → S0, and the next full pattern is required before `z` rises.
